// File: rtl/pattern_hflipper.sv
// rtl/pattern_hflipper.sv - registered horizontal flip and pixel select for one pattern line
//
// Purpose:
//   Optionally mirrors one pattern line horizontally. Pixels are reversed as
//   whole BPP-bit units, so the bits inside each pixel keep their order. The
//   block then picks one pixel from the flipped line. All outputs are
//   registered, so the latency is exactly one clock.
//
// Ports:
//   clk        pixel clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   qualifies pattern/hflip/sel_x this cycle
//   pattern    raw line; pixel 0 (leftmost) is in the most significant BPP bits
//   hflip      1 = mirror the line horizontally
//   sel_x      pixel index into the post-flip line
//   out_valid  registered in_valid
//   out_line   registered flipped (or passed-through) line
//   out_pixel  registered pixel sel_x of the flipped line
module pattern_hflipper #(
    parameter int PIXELS = 8,
    parameter int BPP    = 2,
    localparam int LINE_W = PIXELS * BPP,
    localparam int SEL_W  = $clog2(PIXELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [LINE_W-1:0] pattern,
    input  logic              hflip,
    input  logic [SEL_W-1:0]  sel_x,
    output logic              out_valid,
    output logic [LINE_W-1:0] out_line,
    output logic [BPP-1:0]    out_pixel
);

    logic              valid_q;
    logic              valid_d;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;
    logic [BPP-1:0]    pixel_q;
    logic [BPP-1:0]    pixel_d;

    logic [LINE_W-1:0] flipped;
    logic [BPP-1:0]    selected;

    // Swap whole pixel slots. Each BPP-bit group is copied as one unit, so
    // the bit order inside a pixel never changes.
    always_comb begin
        flipped = pattern;
        if (hflip) begin
            for (int k = 0; k < PIXELS; k++) begin
                flipped[(PIXELS-1-k)*BPP +: BPP] = pattern[k*BPP +: BPP];
            end
        end
    end

    // Pixel 0 sits at the top of the line. A compare-and-select loop keeps
    // the index arithmetic in constant expressions.
    always_comb begin
        selected = '0;
        for (int k = 0; k < PIXELS; k++) begin
            if (sel_x == SEL_W'(k)) begin
                selected = flipped[(PIXELS-1-k)*BPP +: BPP];
            end
        end
    end

    // When there is no valid input, the data registers keep their old values
    // and only the valid flag drops.
    always_comb begin
        valid_d = in_valid;
        line_d  = line_q;
        pixel_d = pixel_q;
        if (in_valid) begin
            line_d  = flipped;
            pixel_d = selected;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            line_q  <= '0;
            pixel_q <= '0;
        end else begin
            valid_q <= valid_d;
            line_q  <= line_d;
            pixel_q <= pixel_d;
        end
    end

    assign out_valid = valid_q;
    assign out_line  = line_q;
    assign out_pixel = pixel_q;

endmodule

// File: tb/tb_pattern_hflipper.sv
// tb/tb_pattern_hflipper.sv - directed self-checking bench for pattern_hflipper
module tb_pattern_hflipper;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] pattern;
    logic        hflip;
    logic [2:0]  sel_x;
    logic        out_valid;
    logic [15:0] out_line;
    logic [1:0]  out_pixel;

    int checks = 0;
    int errors = 0;

    pattern_hflipper dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .pattern   (pattern),
        .hflip     (hflip),
        .sel_x     (sel_x),
        .out_valid (out_valid),
        .out_line  (out_line),
        .out_pixel (out_pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the inputs, clock one rising edge, then settle 1 time unit so the
    // outputs are sampled away from the edge.
    task automatic step(input logic v, input logic [15:0] p, input logic h, input logic [2:0] s);
        in_valid = v;
        pattern  = p;
        hflip    = h;
        sel_x    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] line, input logic [1:0] pix);
        check({tag, ".valid"}, {15'd0, out_valid}, {15'd0, v});
        check({tag, ".line"},  out_line, line);
        check({tag, ".pixel"}, {14'd0, out_pixel}, {14'd0, pix});
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        pattern  = 16'h0000;
        hflip    = 1'b0;
        sel_x    = 3'd0;

        // Reset takes priority over a simultaneous valid input.
        step(1'b1, 16'h1B00, 1'b0, 3'd3);
        check_out("reset", 1'b0, 16'h0000, 2'b00);
        step(1'b1, 16'h1B00, 1'b1, 3'd4);
        check_out("reset2", 1'b0, 16'h0000, 2'b00);

        // The first edge after rst drops captures data.
        rst = 1'b0;
        step(1'b1, 16'h1B00, 1'b0, 3'd3);
        check_out("pass_1B00", 1'b1, 16'h1B00, 2'b11);

        step(1'b1, 16'h1B00, 1'b1, 3'd4);
        check_out("flip_1B00_s4", 1'b1, 16'h00E4, 2'b11);
        step(1'b1, 16'h1B00, 1'b1, 3'd3);
        check_out("flip_1B00_s3", 1'b1, 16'h00E4, 2'b00);

        step(1'b1, 16'h8001, 1'b1, 3'd0);
        check_out("flip_8001_s0", 1'b1, 16'h4002, 2'b01);
        step(1'b1, 16'h8001, 1'b0, 3'd7);
        check_out("pass_8001_s7", 1'b1, 16'h8001, 2'b01);

        // Back-to-back inputs, then two idle cycles with changing inputs that
        // must be ignored while the outputs hold.
        step(1'b1, 16'h8001, 1'b1, 3'd7);
        check_out("stream0", 1'b1, 16'h4002, 2'b10);
        step(1'b1, 16'h8001, 1'b0, 3'd7);
        check_out("stream1", 1'b1, 16'h8001, 2'b01);
        step(1'b0, 16'hFFFF, 1'b1, 3'd2);
        check_out("hold0", 1'b0, 16'h8001, 2'b01);
        step(1'b0, 16'h1234, 1'b0, 3'd5);
        check_out("hold1", 1'b0, 16'h8001, 2'b01);

        // Involution: flip, then feed the flipped line back through.
        step(1'b1, 16'h1234, 1'b1, 3'd1);
        check_out("inv_1234_a", 1'b1, 16'h1C84, 2'b01);
        step(1'b1, 16'h1C84, 1'b1, 3'd3);
        check_out("inv_1234_b", 1'b1, 16'h1234, 2'b10);
        step(1'b1, 16'hA5C3, 1'b1, 3'd0);
        check_out("inv_A5C3_a", 1'b1, 16'hC35A, 2'b11);
        step(1'b1, 16'hC35A, 1'b1, 3'd7);
        check_out("inv_A5C3_b", 1'b1, 16'hA5C3, 2'b11);

        // Symmetric lines are unchanged by the flip.
        step(1'b1, 16'hFFFF, 1'b1, 3'd6);
        check_out("sym_FFFF_f", 1'b1, 16'hFFFF, 2'b11);
        step(1'b1, 16'hFFFF, 1'b0, 3'd6);
        check_out("sym_FFFF_p", 1'b1, 16'hFFFF, 2'b11);
        step(1'b1, 16'h0000, 1'b1, 3'd2);
        check_out("sym_0000_f", 1'b1, 16'h0000, 2'b00);

        // Reset in the middle of a stream clears the outputs.
        step(1'b1, 16'h8001, 1'b0, 3'd0);
        check_out("pre_rst", 1'b1, 16'h8001, 2'b10);
        rst = 1'b1;
        step(1'b1, 16'h8001, 1'b0, 3'd0);
        check_out("mid_rst", 1'b0, 16'h0000, 2'b00);
        rst = 1'b0;
        step(1'b1, 16'h8001, 1'b1, 3'd7);
        check_out("post_rst", 1'b1, 16'h4002, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
